// File: rtl/lc3_pkg.sv
// Shared LC-3 writeback types: result-select enum, NZP condition codes, sizes.
package lc3_pkg;

  localparam int unsigned REG_COUNT = 8;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned REG_IDX_W = $clog2(REG_COUNT);
  localparam int unsigned NZP_W     = 3;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_PC   = 2'd1,
    WB_MEM  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  typedef logic [NZP_W-1:0] nzp_t;

  localparam nzp_t NZP_N = 3'b100;
  localparam nzp_t NZP_Z = 3'b010;
  localparam nzp_t NZP_P = 3'b001;

  // Condition codes for a value being written back; exactly one bit set.
  function automatic nzp_t nzp_of(input logic [WORD_W-1:0] value);
    if (value[WORD_W-1])    return NZP_N;
    else if (value == '0)   return NZP_Z;
    else                    return NZP_P;
  endfunction

endpackage

// File: rtl/lc3_writeback_if.sv
// Writeback-stage bus: result sources and register indices in, read data and flags out.
interface lc3_writeback_if;
  import lc3_pkg::*;

  logic                  enable_writeback;
  logic [1:0]            W_Control;
  logic [WORD_W-1:0]     aluout;
  logic [WORD_W-1:0]     pcout;
  logic [WORD_W-1:0]     memout;
  logic [REG_IDX_W-1:0]  dr;
  logic [REG_IDX_W-1:0]  sr1;
  logic [REG_IDX_W-1:0]  sr2;
  logic [WORD_W-1:0]     VSR1;
  logic [WORD_W-1:0]     VSR2;
  nzp_t                  psr;
  logic                  wb_error;

  modport master (
    output enable_writeback, W_Control, aluout, pcout, memout, dr, sr1, sr2,
    input  VSR1, VSR2, psr, wb_error
  );

  modport slave (
    input  enable_writeback, W_Control, aluout, pcout, memout, dr, sr1, sr2,
    output VSR1, VSR2, psr, wb_error
  );
endinterface

// File: rtl/lc3_regfile.sv
// 8 x 16-bit register file: one synchronous write port, two combinational read ports.
module lc3_regfile
  import lc3_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [REG_IDX_W-1:0]  raddr1,
  input  logic [REG_IDX_W-1:0]  raddr2,
  output logic [WORD_W-1:0]     rdata1,
  output logic [WORD_W-1:0]     rdata2
);

  logic [WORD_W-1:0] regs [REG_COUNT];

  // Reset wins over a same-edge write so that write is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: source mux, register file, NZP flags and sticky reserved-select error.
// Optional write-to-read forwarding is enabled by defining LC3_WB_BYPASS_EN.
module lc3_writeback
  import lc3_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  lc3_writeback_if.slave       bus
);

  wb_sel_e            sel;
  logic               wr_valid;
  logic               wr_rsvd;
  logic [WORD_W-1:0]  wr_data;
  logic [WORD_W-1:0]  rd1;
  logic [WORD_W-1:0]  rd2;
  nzp_t               psr_q;
  logic               err_q;

  assign sel = wb_sel_e'(bus.W_Control);

  // Source select; the reserved encoding never produces a write.
  always_comb begin
    wr_data  = bus.aluout;
    wr_valid = 1'b0;
    wr_rsvd  = 1'b0;
    case (sel)
      WB_ALU:  begin wr_data = bus.aluout; wr_valid = bus.enable_writeback; end
      WB_PC:   begin wr_data = bus.pcout;  wr_valid = bus.enable_writeback; end
      WB_MEM:  begin wr_data = bus.memout; wr_valid = bus.enable_writeback; end
      WB_RSVD: begin wr_rsvd = bus.enable_writeback; end
      default: begin wr_valid = 1'b0; end
    endcase
  end

  lc3_regfile u_regfile (
    .clock  (clock),
    .reset  (reset),
    .we     (wr_valid),
    .waddr  (bus.dr),
    .wdata  (wr_data),
    .raddr1 (bus.sr1),
    .raddr2 (bus.sr2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  // Flags follow the written value; reserved selects only raise the sticky error.
  always_ff @(posedge clock) begin
    if (reset) begin
      psr_q <= NZP_Z;
      err_q <= 1'b0;
    end else begin
      if (wr_valid) psr_q <= nzp_of(wr_data);
      if (wr_rsvd)  err_q <= 1'b1;
    end
  end

  assign bus.psr      = psr_q;
  assign bus.wb_error = err_q;

`ifdef LC3_WB_BYPASS_EN
  // Forward the in-flight write to a matching read port in the same cycle.
  assign bus.VSR1 = (wr_valid && (bus.dr == bus.sr1)) ? wr_data : rd1;
  assign bus.VSR2 = (wr_valid && (bus.dr == bus.sr2)) ? wr_data : rd2;
`else
  assign bus.VSR1 = rd1;
  assign bus.VSR2 = rd2;
`endif

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: register-array model compared every cycle plus directed literals.
module tb_lc3_writeback;

  logic clock = 1'b0;
  logic reset;

  lc3_writeback_if bus ();

  lc3_writeback dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model: eight words, NZP flags, sticky error.
  logic [15:0] m_reg [8];
  logic [2:0]  m_psr;
  logic        m_err;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sel_value();
    case (bus.W_Control)
      2'd0:    return bus.aluout;
      2'd1:    return bus.pcout;
      default: return bus.memout;
    endcase
  endfunction

  function automatic logic [15:0] expect_read(input logic [2:0] idx);
`ifdef LC3_WB_BYPASS_EN
    if (bus.enable_writeback && bus.W_Control != 2'd3 && bus.dr == idx) return sel_value();
`endif
    return m_reg[idx];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      foreach (m_reg[i]) m_reg[i] = 16'h0000;
      m_psr   = 3'b010;
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && bus.enable_writeback) begin
      if (bus.W_Control == 2'd3) begin
        m_err = 1'b1;
      end else begin
        m_reg[bus.dr] = sel_value();
        if (sel_value() == 16'h0000) m_psr = 3'b010;
        else if (sel_value() >= 16'h8000) m_psr = 3'b100;
        else m_psr = 3'b001;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_vsr1", bus.VSR1, expect_read(bus.sr1));
      check("model_vsr2", bus.VSR2, expect_read(bus.sr2));
      check("model_psr", 16'(bus.psr), 16'(m_psr));
      check("model_err", 16'(bus.wb_error), 16'(m_err));
    end
  end

  // Apply inputs just after a rising edge, then return at the following falling edge.
  task automatic cyc(input logic rst, input logic en, input logic [1:0] wc,
                     input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] mem,
                     input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    @(posedge clock);
    #1;
    reset                = rst;
    bus.enable_writeback = en;
    bus.W_Control        = wc;
    bus.aluout           = alu;
    bus.pcout            = pc;
    bus.memout           = mem;
    bus.dr               = d;
    bus.sr1              = s1;
    bus.sr2              = s2;
    @(negedge clock);
  endtask

  task automatic idle(input logic [2:0] s1, input logic [2:0] s2);
    cyc(1'b0, 1'b0, 2'd0, 16'hDEAD, 16'hBEEF, 16'hCAFE, 3'd0, s1, s2);
  endtask

  logic [15:0] exp_byp;

  initial begin
    reset = 1'b1;
    bus.enable_writeback = 1'b0;
    bus.W_Control = 2'd0;
    bus.aluout = '0; bus.pcout = '0; bus.memout = '0;
    bus.dr = '0; bus.sr1 = '0; bus.sr2 = '0;

    cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
    cyc(1'b1, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);

    // Reset state on all read indices.
    for (int i = 0; i < 8; i++) begin
      idle(3'(i), 3'(7 - i));
      check("reset_vsr1", bus.VSR1, 16'h0000);
      check("reset_vsr2", bus.VSR2, 16'h0000);
    end
    check("reset_psr", 16'(bus.psr), 16'h0002);
    check("reset_err", 16'(bus.wb_error), 16'h0000);

    // ALU write, negative value.
    cyc(1'b0, 1'b1, 2'd0, 16'h8001, 16'h1111, 16'h2222, 3'd3, 3'd3, 3'd0);
    idle(3'd3, 3'd1);
    check("alu_vsr1", bus.VSR1, 16'h8001);
    check("alu_psr_n", 16'(bus.psr), 16'h0004);

    // MEM zero, then PC positive to the same register.
    cyc(1'b0, 1'b1, 2'd2, 16'h7777, 16'h6666, 16'h0000, 3'd5, 3'd0, 3'd0);
    idle(3'd0, 3'd5);
    check("mem_psr_z", 16'(bus.psr), 16'h0002);
    cyc(1'b0, 1'b1, 2'd1, 16'hFFFF, 16'h3005, 16'h8888, 3'd5, 3'd0, 3'd0);
    idle(3'd0, 3'd5);
    check("pc_vsr2", bus.VSR2, 16'h3005);
    check("pc_psr_p", 16'(bus.psr), 16'h0001);

    // Reserved select: no write, psr held, error sticky.
    cyc(1'b0, 1'b1, 2'd0, 16'h0042, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
    cyc(1'b0, 1'b1, 2'd3, 16'h1234, 16'h1234, 16'h1234, 3'd2, 3'd2, 3'd2);
    check("rsvd_no_fwd", bus.VSR1, 16'h0042);
    idle(3'd2, 3'd2);
    check("rsvd_r2", bus.VSR1, 16'h0042);
    check("rsvd_psr", 16'(bus.psr), 16'h0001);
    check("rsvd_err", 16'(bus.wb_error), 16'h0001);
    cyc(1'b0, 1'b1, 2'd0, 16'h8000, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
    idle(3'd0, 3'd0);
    check("r0_write", bus.VSR1, 16'h8000);
    check("err_sticky", 16'(bus.wb_error), 16'h0001);

    // R7 write, same index on both ports.
    cyc(1'b0, 1'b1, 2'd1, 16'h0, 16'h7ABC, 16'h0, 3'd7, 3'd0, 3'd0);
    idle(3'd7, 3'd7);
    check("r7_vsr1", bus.VSR1, 16'h7ABC);
    check("r7_vsr2", bus.VSR2, 16'h7ABC);

    // Disabled writeback holds registers and flags.
    cyc(1'b0, 1'b0, 2'd0, 16'h5555, 16'h5555, 16'h5555, 3'd3, 3'd3, 3'd3);
    idle(3'd3, 3'd3);
    check("hold_r3", bus.VSR1, 16'h8001);
    check("hold_psr", 16'(bus.psr), 16'h0001);

    // Same-cycle read of the register being written.
    cyc(1'b0, 1'b1, 2'd0, 16'h1111, 16'h0, 16'h0, 3'd4, 3'd0, 3'd0);
    cyc(1'b0, 1'b1, 2'd0, 16'h00FF, 16'h0, 16'h0, 3'd4, 3'd4, 3'd4);
`ifdef LC3_WB_BYPASS_EN
    exp_byp = 16'h00FF;
`else
    exp_byp = 16'h1111;
`endif
    check("same_cycle_vsr1", bus.VSR1, exp_byp);
    idle(3'd4, 3'd4);
    check("after_write_r4", bus.VSR1, 16'h00FF);

    // Reset wins over a same-edge write.
    cyc(1'b1, 1'b1, 2'd0, 16'hBEEF, 16'hBEEF, 16'hBEEF, 3'd6, 3'd6, 3'd3);
    idle(3'd6, 3'd3);
    check("rst_r6", bus.VSR1, 16'h0000);
    check("rst_r3", bus.VSR2, 16'h0000);
    check("rst_psr", 16'(bus.psr), 16'h0002);
    check("rst_err", 16'(bus.wb_error), 16'h0000);

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
          16'($urandom), 16'($urandom_range(0, 1) != 0 ? $urandom : 0), 16'($urandom),
          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    idle(3'd0, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
LC3_WRITEBACK -- requirements
Module: lc3_writeback

Interface
REQ-001 The block SHALL have no parameters; all sizes SHALL be fixed by package constants.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clock  in  1: single clock; all state changes on its rising edge.
- reset  in  1: synchronous, active-high reset.
- enable_writeback  in  1: qualifies a writeback this cycle.
- W_Control  in  2: result source select (0 ALU, 1 PC, 2 MEM, 3 reserved).
- aluout  in  16: execute-stage result.
- pcout  in  16: PC-relative result.
- memout  in  16: memory load data.
- dr  in  3: destination register index.
- sr1  in  3: read port 1 index.
- sr2  in  3: read port 2 index.
- VSR1  out  16: read data for sr1, feeding execute aluin1.
- VSR2  out  16: read data for sr2, feeding execute aluin2.
- psr  out  3: condition codes {N,Z,P}.
- wb_error  out  1: sticky flag set by a reserved select.

Function
REQ-003 Register file SHALL hold 8 x 16-bit registers R0..R7.
REQ-004 When enable_writeback=1 and W_Control is 0, 1 or 2, the block SHALL write the selected source (aluout, pcout or memout) into R[dr] on the next rising edge.
REQ-005 Writes SHALL take one cycle; written data SHALL be visible on VSR1/VSR2 in the cycle after the edge.
REQ-006 VSR1/VSR2 SHALL be combinational reads of R[sr1]/R[sr2]; sr1==sr2 SHALL return identical data on both ports.
REQ-007 On every qualifying write, psr SHALL update in the same edge from the written value: N=bit15; Z=value==0; P=otherwise; exactly one bit set.
REQ-008 With enable_writeback=0, registers and psr SHALL hold.
REQ-009 W_Control=3 with enable_writeback=1 SHALL suppress the register write, hold psr, and set wb_error=1.
REQ-010 wb_error SHALL stay set until reset.
REQ-011 Writes to dr=7 and dr=0 SHALL behave identically to other indices; no register is hardwired.
REQ-012 Input values other than the selected source SHALL have no effect.

Reset
REQ-013 reset SHALL take priority over enable_writeback in the same cycle.
REQ-014 On reset, R0..R7 SHALL be 16'h0000, psr SHALL be 3'b010 (Z) and wb_error SHALL be 0.
REQ-015 Reset asserted at the same edge as a qualifying write SHALL discard that write.
REQ-016 VSR1/VSR2 SHALL read 16'h0000 in the cycle after reset.

Configuration
REQ-017 Macro LC3_WB_BYPASS_EN SHALL control write-to-read forwarding.
REQ-018 With LC3_WB_BYPASS_EN defined, a qualifying write with dr==sr1 (or dr==sr2) SHALL drive the incoming write data combinationally onto VSR1 (or VSR2) in the same cycle.
REQ-019 Without LC3_WB_BYPASS_EN, reads SHALL return the old register contents until the edge completes.
REQ-020 A reserved-select write (REQ-009) SHALL never be forwarded.
REQ-021 Reset SHALL not depend on the macro.

Structure
REQ-022 Shared package lc3_pkg SHALL hold:
- the W_Control enum (WB_ALU=0, WB_PC=1, WB_MEM=2, WB_RSVD=3);
- the NZP typedef and constants NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001;
- REG_COUNT=8 and WORD_W=16.
REQ-023 Storage SHALL be a sub-module lc3_regfile with 1 write port and 2 read ports; source mux, psr logic, bypass and wb_error SHALL live in lc3_writeback.

Verification
REQ-024 Reset release then read of sr1=0..7 -> all 16'h0000, psr=3'b010, wb_error=0.
REQ-025 W_Control=0, aluout=16'h8001, dr=3, enable=1, then sr1=3 -> VSR1=16'h8001, psr=3'b100.
REQ-026 W_Control=2, memout=16'h0000, dr=5 -> psr=3'b010; then W_Control=1, pcout=16'h3005, dr=5 -> VSR2(sr2=5)=16'h3005, psr=3'b001.
REQ-027 W_Control=3, dr=2, aluout=16'h1234 -> R2 unchanged, psr unchanged, wb_error=1 sticky until reset.
REQ-028 Same-cycle write dr=4 with sr1=4, aluout=16'h00FF -> VSR1=16'h00FF in that cycle with LC3_WB_BYPASS_EN defined, old R4 value without it.
REQ-029 reset=1 together with a qualifying write (dr=6, 16'hBEEF) -> R6=16'h0000, psr=3'b010.
